// File: rtl/fifo_burst_reader.sv
// Burst reader for a non-showahead FIFO: waits for BURST_LEN buffered words, then drains them
// onto a valid/ready stream with sop/eop framing. Optional macro BURST_TIMEOUT_EN flushes partial data.
module fifo_burst_reader #(
    parameter int DWIDTH         = 16,
    parameter int AWIDTH         = 8,
    parameter int BURST_LEN      = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DWIDTH-1:0] fifo_q_i,
    input  logic              fifo_empty_i,
    input  logic [AWIDTH:0]   fifo_usedw_i,
    output logic              fifo_rdreq_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              sop_o,
    output logic              eop_o,
    output logic              busy_o
);
    localparam int CW = $clog2(BURST_LEN + 1);
    localparam int LW = AWIDTH + 1;
    localparam int EW = DWIDTH + 2;

    if (BURST_LEN < 1 || BURST_LEN > 2**AWIDTH || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("fifo_burst_reader: illegal BURST_LEN or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   req_cnt_q, req_cnt_d;
    logic [EW-1:0]   head_q, head_d;
    logic [EW-1:0]   tail_q, tail_d;
    logic [1:0]      occ_q, occ_d;
    logic            inflight_q;
    logic [1:0]      tag_q;
    logic [1:0]      new_tag;
    logic [LW-1:0]   blen;
    logic [2:0]      level;
    logic            pop;
    logic            req_last;
    logic            full_burst;

`ifdef BURST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]   timer_q, timer_d;
    logic [LW-1:0]   blen_q, blen_d;
    logic            partial;
    logic            timeout;

    assign blen    = blen_q;
    assign partial = !fifo_empty_i && (fifo_usedw_i < LW'(BURST_LEN));
    assign timeout = partial && (timer_q == TW'(TIMEOUT_CYCLES));
`else
    assign blen = LW'(BURST_LEN);
`endif

    assign valid_o    = (occ_q != 2'd0);
    assign pop        = valid_o && ready_i;
    assign busy_o     = (state_q != IDLE);
    assign data_o     = head_q[EW-1:2];
    assign sop_o      = head_q[1];
    assign eop_o      = head_q[0];
    assign full_burst = (fifo_usedw_i >= LW'(BURST_LEN));

    // Words held plus the read in flight, minus the one leaving this cycle, must leave room.
    assign level        = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    assign fifo_rdreq_o = (state_q == BURST) && !fifo_empty_i && (level < 3'd2);

    assign req_last = (LW'(req_cnt_q) == blen - LW'(1));
    assign new_tag  = {(req_cnt_q == '0), req_last};

    always_comb begin
        state_d   = state_q;
        req_cnt_d = req_cnt_q;
`ifdef BURST_TIMEOUT_EN
        blen_d    = blen_q;
        timer_d   = '0;
`endif
        case (state_q)
            IDLE: begin
                if (full_burst) begin
                    state_d   = BURST;
                    req_cnt_d = '0;
`ifdef BURST_TIMEOUT_EN
                    blen_d    = LW'(BURST_LEN);
                end else if (timeout) begin
                    state_d   = BURST;
                    req_cnt_d = '0;
                    blen_d    = fifo_usedw_i;
                end else if (partial) begin
                    timer_d   = timer_q + TW'(1);
`endif
                end
            end
            BURST: begin
                if (fifo_rdreq_o) begin
                    req_cnt_d = req_cnt_q + CW'(1);
                    if (req_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && eop_o) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Two-entry output buffer: head drives the stream, tail absorbs a capture while head stalls.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({inflight_q, pop})
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = {fifo_q_i, tag_q};
                end else begin
                    tail_d = {fifo_q_i, tag_q};
                end
                occ_d = occ_q + 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = {fifo_q_i, tag_q};
                end else begin
                    head_d = tail_q;
                    tail_d = {fifo_q_i, tag_q};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            req_cnt_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            tag_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            req_cnt_q  <= req_cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            inflight_q <= fifo_rdreq_o;
            tag_q      <= new_tag;
        end
    end

`ifdef BURST_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            timer_q <= '0;
            blen_q  <= LW'(BURST_LEN);
        end else begin
            timer_q <= timer_d;
            blen_q  <= blen_d;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader (default build, BURST_LEN=16) with a behavioural
// non-showahead FIFO model and a negedge stream monitor.
module tb_fifo_burst_reader;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int UW = AW + 1;
    localparam int BL = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] fifo_q = '0;
    logic          fifo_empty;
    logic [AW:0]   fifo_usedw;
    logic          fifo_rdreq;
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;
    logic          sop;
    logic          eop;
    logic          busy;

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .DWIDTH(DW), .AWIDTH(AW), .BURST_LEN(BL), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .fifo_q_i(fifo_q), .fifo_empty_i(fifo_empty),
        .fifo_usedw_i(fifo_usedw), .fifo_rdreq_o(fifo_rdreq), .data_o(data), .valid_o(valid),
        .ready_i(ready), .sop_o(sop), .eop_o(eop), .busy_o(busy)
    );

    // FIFO model: read data appears the cycle after rdreq.
    logic [DW-1:0] mem [0:511];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int underflow = 0;

    assign fifo_usedw = UW'(wr_ptr - rd_ptr);
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 0;
        end else if (fifo_rdreq) begin
            if (wr_ptr == rd_ptr) underflow <= underflow + 1;
            fifo_q <= mem[rd_ptr % 512];
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Stream monitor: a handshake seen at negedge completes on the following posedge.
    logic [DW-1:0] rx_data [0:255];
    logic          rx_sop  [0:255];
    logic          rx_eop  [0:255];
    int            rx_cyc  [0:255];
    int rx_cnt = 0, cyc = 0, issued = 0, popped = 0, max_out = 0, stall_viol = 0;
    logic          prev_stall = 1'b0;
    logic [DW+1:0] prev_out = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            issued     <= 0;
            popped     <= 0;
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && !(valid && ({data, sop, eop} === prev_out)))
                stall_viol <= stall_viol + 1;
            prev_stall <= valid && !ready;
            prev_out   <= {data, sop, eop};
            if (fifo_rdreq) issued <= issued + 1;
            if (valid && ready) begin
                rx_data[rx_cnt] <= data;
                rx_sop[rx_cnt]  <= sop;
                rx_eop[rx_cnt]  <= eop;
                rx_cyc[rx_cnt]  <= cyc;
                rx_cnt          <= rx_cnt + 1;
                popped          <= popped + 1;
            end
            if (issued + int'(fifo_rdreq) - popped - int'(valid && ready) > max_out)
                max_out <= issued + int'(fifo_rdreq) - popped - int'(valid && ready);
        end
    end

    int tests = 0;
    int failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_words(input logic [DW-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr % 512] = first + DW'(i);
            wr_ptr++;
        end
    endtask

    task automatic wait_rx(input string tag, input int target, input int budget);
        int k;
        k = 0;
        while (rx_cnt < target && k < budget) begin
            step(1);
            k++;
        end
        chk(tag, 32'(rx_cnt >= target), 32'd1);
    endtask

    task automatic check_burst(input string tag, input int base, input int n,
                               input logic [DW-1:0] first, input int blen);
        int de, se, ee;
        de = 0; se = 0; ee = 0;
        for (int i = 0; i < n; i++) begin
            if (rx_data[base+i] !== first + DW'(i)) de++;
            if (rx_sop[base+i] !== ((i % blen) == 0)) se++;
            if (rx_eop[base+i] !== ((i % blen) == blen - 1)) ee++;
        end
        chk({tag, "_data_errs"}, 32'(de), 32'd0);
        chk({tag, "_sop_errs"}, 32'(se), 32'd0);
        chk({tag, "_eop_errs"}, 32'(ee), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, iss0;
        logic [3:0] pat;

        rst_n = 1'b0;
        ready = 1'b1;
        step(3);
        chk("rst_rdreq", 32'(fifo_rdreq), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_sop", 32'(sop), 32'd0);
        chk("rst_eop", 32'(eop), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step(2);

        // Full burst with ready high: latency, order, framing, contiguity.
        base = rx_cnt;
        write_words(16'h0001, 16);
        step(1);
        chk("t1_busy_on_start", 32'(busy), 32'd1);
        chk("t1_rdreq_first", 32'(fifo_rdreq), 32'd1);
        chk("t1_valid_c1", 32'(valid), 32'd0);
        step(1);
        chk("t1_valid_c2", 32'(valid), 32'd0);
        step(1);
        chk("t1_valid_c3", 32'(valid), 32'd1);
        chk("t1_first_data", 32'(data), 32'h0001);
        chk("t1_first_sop", 32'(sop), 32'd1);
        wait_rx("t1_timeout", base + 16, 100);
        chk("t1_busy_after_eop", 32'(busy), 32'd0);
        chk("t1_valid_after_eop", 32'(valid), 32'd0);
        check_burst("t1", base, 16, 16'h0001, BL);
        chk("t1_contiguous", 32'(rx_cyc[base+15] - rx_cyc[base]), 32'd15);

        // 15 words never start a burst; the 16th does.
        base = rx_cnt;
        iss0 = issued;
        write_words(16'h0100, 15);
        step(1000);
        chk("t2_no_reads", 32'(issued - iss0), 32'd0);
        chk("t2_no_valid", 32'(rx_cnt - base), 32'd0);
        chk("t2_idle", 32'(busy), 32'd0);
        write_words(16'h010F, 1);
        wait_rx("t2_timeout", base + 16, 100);
        check_burst("t2", base, 16, 16'h0100, BL);

        // Backpressure with ready pattern 1,0,0,1.
        base = rx_cnt;
        pat = 4'b1001;
        write_words(16'h0200, 16);
        for (int k = 0; k < 400 && rx_cnt < base + 16; k++) begin
            ready = pat[k % 4];
            step(1);
        end
        ready = 1'b1;
        chk("t3_count", 32'(rx_cnt - base), 32'd16);
        check_burst("t3", base, 16, 16'h0200, BL);
        chk("t3_stall_stable", 32'(stall_viol), 32'd0);
        chk("t3_outstanding_le2", 32'(max_out <= 2), 32'd1);
        step(3);

        // 40 words: two back-to-back bursts, 8 words left behind.
        base = rx_cnt;
        write_words(16'h0300, 40);
        wait_rx("t4_timeout", base + 32, 200);
        step(50);
        chk("t4_count", 32'(rx_cnt - base), 32'd32);
        check_burst("t4", base, 32, 16'h0300, BL);
        chk("t4_usedw_left", 32'(fifo_usedw), 32'd8);
        chk("t4_idle", 32'(busy), 32'd0);
        chk("t4_no_rdreq", 32'(fifo_rdreq), 32'd0);

        // Asynchronous reset mid-burst, then a clean burst.
        rst_n = 1'b0;
        wr_ptr = 0;
        step(2);
        rst_n = 1'b1;
        step(2);
        base = rx_cnt;
        write_words(16'h0400, 16);
        wait_rx("t5_pre_timeout", base + 5, 100);
        #2;
        rst_n = 1'b0;
        wr_ptr = 0;
        #1;
        chk("t5_async_valid", 32'(valid), 32'd0);
        chk("t5_async_rdreq", 32'(fifo_rdreq), 32'd0);
        chk("t5_async_busy", 32'(busy), 32'd0);
        chk("t5_async_sop", 32'(sop), 32'd0);
        chk("t5_async_eop", 32'(eop), 32'd0);
        chk("t5_async_data", 32'(data), 32'd0);
        step(2);
        chk("t5_count_at_reset", 32'(rx_cnt - base), 32'd5);
        rst_n = 1'b1;
        step(2);
        base = rx_cnt;
        write_words(16'h0500, 16);
        wait_rx("t5_timeout", base + 16, 100);
        step(5);
        chk("t5_count", 32'(rx_cnt - base), 32'd16);
        check_burst("t5", base, 16, 16'h0500, BL);
        chk("fifo_underflow", 32'(underflow), 32'd0);
        chk("final_stall_stable", 32'(stall_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
